// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: control-field
// bit positions and the occupancy encoding of a stage.
package pipe_pkg;

  localparam int CTRL_W        = 5;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG_LO = 3;
  localparam int CTRL_MEMTOREG_HI = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag, control field and payload.
// Clear drops valid and control but keeps the payload; clear beats load.
module pipe_entry_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// bubble-gated control and an optional skid entry for a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  import pipe_pkg::*;

  logic              accept, emit;
  logic              main_load, main_clear;
  logic [CTRL_W-1:0] main_d_ctrl, main_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  assign out_ctrl = out_valid ? main_ctrl : '0;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (out_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      occ_state_t        state, nxt;
      logic              in_ready_r;
      logic              skid_load, skid_clear, skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .q_valid (skid_valid),
        .q_ctrl  (skid_ctrl),
        .q_data  (skid_data)
      );

      // A valid skid entry only exists in TWO, so it is the older item and refills main first.
      assign main_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
      assign main_d_data = skid_valid ? skid_data : in_data;
      assign in_ready    = in_ready_r;
      assign occupancy   = state;

      always_comb begin
        nxt        = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
          nxt        = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else begin
          case (state)
            ST_EMPTY: if (accept) begin
              nxt       = ST_ONE;
              main_load = 1'b1;
            end
            ST_ONE: begin
              if (accept && emit) begin
                main_load = 1'b1;
              end else if (accept) begin
                nxt       = ST_TWO;
                skid_load = 1'b1;
              end else if (emit) begin
                nxt        = ST_EMPTY;
                main_clear = 1'b1;
              end
            end
            ST_TWO: if (emit) begin
              nxt        = ST_ONE;
              main_load  = 1'b1;
              skid_clear = 1'b1;
            end
            default: nxt = ST_EMPTY;
          endcase
        end
      end

      // in_ready is registered from the next state, so out_ready never reaches it combinationally.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state      <= ST_EMPTY;
          in_ready_r <= 1'b1;
        end else begin
          state      <= nxt;
          in_ready_r <= (nxt != ST_TWO);
        end
      end
    end else begin : g_noskid
      assign in_ready    = out_ready | ~out_valid;
      assign main_d_ctrl = in_ctrl;
      assign main_d_data = in_data;
      assign main_load   = accept & ~flush;
      assign main_clear  = flush | (emit & ~accept);
      assign occupancy   = {1'b0, out_valid};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg, SKID=1 and SKID=0 builds
// driven from shared stimulus, each checked against a queue-based model.
module tb_pipe_stage_reg;

  localparam int CW = 5;
  localparam int DW = 64;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          rdy1, ov1, rdy0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  int compared = 0;
  int mismatched = 0;

  ent_t          q1[$];
  ent_t          q0[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last0 = '0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1),
    .out_data(od1), .occupancy(occ1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0),
    .out_data(od0), .occupancy(occ0)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] ec1, ec0;
    logic [DW-1:0] ed1, ed0;
    ec1 = (q1.size() > 0) ? q1[0][CW+DW-1:DW] : '0;
    ec0 = (q0.size() > 0) ? q0[0][CW+DW-1:DW] : '0;
    ed1 = (q1.size() > 0) ? q1[0][DW-1:0] : last1;
    ed0 = (q0.size() > 0) ? q0[0][DW-1:0] : last0;
    check_eq("s1_in_ready", 64'(rdy1), 64'(q1.size() < 2));
    check_eq("s1_out_valid", 64'(ov1), 64'(q1.size() > 0));
    check_eq("s1_out_ctrl", 64'(oc1), 64'(ec1));
    check_eq("s1_out_data", od1, ed1);
    check_eq("s1_occupancy", 64'(occ1), 64'(q1.size()));
    check_eq("s0_in_ready", 64'(rdy0), 64'(out_ready || q0.size() == 0));
    check_eq("s0_out_valid", 64'(ov0), 64'(q0.size() > 0));
    check_eq("s0_out_ctrl", 64'(oc0), 64'(ec0));
    check_eq("s0_out_data", od0, ed0);
    check_eq("s0_occupancy", 64'(occ0), 64'(q0.size()));
  endtask

  // Inputs are already set; check current outputs, then model the next edge.
  task automatic cycle();
    bit a1, e1, a0, e0;
    #1;
    check_all();
    a1 = in_valid && (q1.size() < 2);
    e1 = out_ready && (q1.size() > 0);
    a0 = in_valid && (out_ready || q0.size() == 0);
    e0 = out_ready && (q0.size() > 0);
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (e1) void'(q1.pop_front());
      if (a1) q1.push_back({in_ctrl, in_data});
      if (e0) void'(q0.pop_front());
      if (a0) q0.push_back({in_ctrl, in_data});
    end
    if (q1.size() > 0) last1 = q1[0][DW-1:0];
    if (q0.size() > 0) last0 = q0[0][DW-1:0];
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'b10011, 64'h10 + 64'(i), 1'b1, 1'b0);
      cycle();
      check_eq("stream_occ_le1", 64'(occ1 <= 2'd1), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Stall into skid
    drive(1'b1, 5'b00001, 64'hA1, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'b00001, 64'hA2, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'b00001, 64'hA3, 1'b0, 1'b0); cycle();
    check_eq("stall_in_ready", 64'(rdy1), 64'd0);
    check_eq("stall_occ", 64'(occ1), 64'd2);
    check_eq("stall_data", od1, 64'hA1);
    cycle();
    check_eq("stall_data_stable", od1, 64'hA1);
    drive(1'b1, 5'b00001, 64'hA3, 1'b1, 1'b0); cycle();
    check_eq("release_first", od1, 64'hA2);
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cycle();

    // Flush while full, with an incoming instruction
    drive(1'b1, 5'b00111, 64'hC1, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'b00111, 64'hC2, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'b00111, 64'hB0, 1'b0, 1'b1); cycle();
    check_eq("flush_valid", 64'(ov1), 64'd0);
    check_eq("flush_ctrl", 64'(oc1), 64'd0);
    check_eq("flush_occ", 64'(occ1), 64'd0);
    check_eq("flush_ready", 64'(rdy1), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) cycle();

    // Bubble gating
    drive(1'b1, 5'b11111, 64'hCAFE, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0); cycle();
    check_eq("bubble_valid", 64'(ov1), 64'd0);
    check_eq("bubble_ctrl", 64'(oc1), 64'd0);
    check_eq("bubble_data", od1, 64'hCAFE);

    // SKID=0 combinational ready
    drive(1'b1, 5'b00010, 64'hD1, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'b00010, 64'hD2, 1'b0, 1'b0); #1;
    check_eq("s0_stall_ready", 64'(rdy0), 64'd0);
    out_ready = 1'b1; #1;
    check_eq("s0_release_ready", 64'(rdy0), 64'd1);
    cycle();
    check_eq("s0_pass_data", od0, 64'hD2);
    check_eq("s0_pass_valid", 64'(ov0), 64'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      cycle();
    end

    // Reset mid-cycle with traffic in flight
    drive(1'b1, 5'b10101, 64'hEE, 1'b0, 1'b0); cycle();
    cycle();
    #2 reset = 1'b1; #1;
    check_eq("rst_valid", 64'(ov1), 64'd0);
    check_eq("rst_ctrl", 64'(oc1), 64'd0);
    check_eq("rst_data", od1, 64'd0);
    check_eq("rst_occ", 64'(occ1), 64'd0);
    check_eq("rst_ready", 64'(rdy1), 64'd1);
    check_eq("rst_s0_data", od0, 64'd0);
    q1.delete(); q0.delete(); last1 = '0; last0 = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    drive(1'b1, 5'b01000, 64'hF0, 1'b1, 1'b0);
    @(posedge clk); #1;
    q1.push_back({5'b01000, 64'hF0}); q0.push_back({5'b01000, 64'hF0});
    last1 = 64'hF0; last0 = 64'hF0;
    check_eq("post_rst_accept", od1, 64'hF0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cycle();
    #1 check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload between stages.
- Adds per-entry valid, a valid/ready handshake (stall), synchronous flush (bubble insertion), and an optional skid entry so upstream ready can be registered.
- Control bits are forced to zero whenever the stage holds a bubble, so a flushed or empty stage never writes registers or memory.

Parameters:
CTRL_W, 5, width of control field (e.g. RegWrite, MemRead, MemWrite, MemtoReg[1:0]); zeroed on bubble
DATA_W, 64, width of payload (register numbers, operands, ALU result, PC values); not cleared on bubble
SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries (main + skid) with registered in_ready

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  upstream stage presents an instruction
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream payload
flush  input  1  synchronous kill of all held entries (branch/jump/exception)
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  downstream accepts (0 = stall)
out_ctrl  output  CTRL_W  control field; all-zero when out_valid=0
out_data  output  DATA_W  payload; holds last value when out_valid=0
occupancy  output  2  entries held (0..1 if SKID=0, 0..2 if SKID=1)

Behaviour:
- Reset, asynchronous:
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 (SKID=1 registered value); skid entry cleared.
  - Reset asserted mid-transfer discards everything; the first accept after reset deasserts occurs on the next rising edge.
- Transfer definitions: accept = in_valid & in_ready; emit = out_valid & out_ready; both evaluated at the rising edge.
- Latency: one cycle from accept to out_valid when the stage is empty.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On accept the main register loads in_ctrl/in_data and out_valid=1.
  - On emit without accept, out_valid=0.
  - Accept and emit in the same cycle: the register reloads and out_valid stays 1, giving full throughput.
- SKID=1 state machine: EMPTY(occ 0), ONE(occ 1), TWO(occ 2); in_ready = (state != TWO), registered.
  - EMPTY: accept -> ONE.
  - ONE: accept & emit -> ONE (main reloads); accept & ~emit -> TWO (input goes to skid); emit & ~accept -> EMPTY.
  - TWO: emit -> ONE (skid moves to main); no accept is possible.
  - Ordering is strictly FIFO; out_* always reflect the main entry.
- Flush:
  - All entries are invalidated at the edge: state EMPTY, occupancy 0, out_valid=0, out_ctrl=0.
  - Flush overrides a simultaneous accept; the incoming instruction is dropped.
  - out_data is not cleared.
  - in_ready is 1 in the cycle after flush.
- Bubble gating: out_ctrl = out_valid ? main_ctrl : 0, applied combinationally after the register.
- Stall: while out_ready=0 and the stage is full, main and skid contents must stay bit-stable.
- No combinational path from in_valid to out_*. With SKID=1 there is also no combinational path from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for control bit positions (CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_MEMTOREG=4:3) and CTRL_W=5;
  - occupancy state encoding (ST_EMPTY=0, ST_ONE=1, ST_TWO=2).
- One sub-module, pipe_entry_reg: a single valid+ctrl+data register with load/clear controls and asynchronous reset. It is instantiated once for main and, under generate (SKID=1), once for skid.
- The top level contains only the occupancy FSM and handshake logic.

Test Plan:
- Reset: assert reset mid-cycle with in_valid=1 -> immediately out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, 8 back-to-back accepts of data 0x10..0x17, ctrl=5'b10011 -> out_data 0x10..0x17 each one cycle later, no gaps, occupancy never exceeds 1.
- Stall with SKID=1: hold out_ready=0 while sending 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 are accepted; in_ready=0 after the second accept; occupancy=2; out_data=0xA1 stable. Release out_ready -> 0xA1, 0xA2, 0xA3 emitted in order.
- Flush while TWO, with a simultaneous in_valid of 0xB0 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xB0 is never emitted.
- Bubble gating: accept ctrl=5'b11111, then emit with no new input -> out_valid=0 and out_ctrl=5'b00000, while out_data still equals the last payload.
- SKID=0 build: out_ready=0 with a full stage -> in_ready=0 in the same cycle; raising out_ready -> in_ready=1 combinationally, and accept plus emit occur on the same edge.
